// File: rtl/uart_port_sharer_pkg.sv
// Shared types and constants for the CoreUART port sharer.
// Contents: FSM state encoding, rx_err bit positions, settle-counter width.
// Imported by uart_port_sharer and uart_rr_lock_arb.
package uart_port_sharer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_TX_WAIT = 3'd2,
    ST_READ    = 3'd3,
    ST_RX_WAIT = 3'd4
  } state_e;

  // Bit positions inside rx_err
  localparam int RX_ERR_PAR = 0;
  localparam int RX_ERR_FRM = 1;
  localparam int RX_ERR_OVF = 2;

  // Settle counters hold values 0..6 (TX_SETTLE/RX_SETTLE <= 7)
  localparam int SETTLE_W = 3;

endpackage

// File: rtl/uart_rr_lock_arb.sv
// Two-way round-robin arbiter that locks onto the winner for a whole packet.
// Ports: i_valid/i_last per requester, i_accept (winner's byte taken this cycle),
//        i_timeout (revoke lock); o_winner one-hot eligible requester, o_grant lock owner.
module uart_rr_lock_arb
  import uart_port_sharer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_valid,
  input  logic [1:0] i_last,
  input  logic       i_accept,
  input  logic       i_timeout,
  output logic [1:0] o_winner,
  output logic [1:0] o_grant
);

  logic [1:0] r_grant;
  logic       r_ptr;      // 0: requester 0 preferred on a tie
  logic [1:0] w_winner;
  logic       w_win_idx;

  // While locked only the owner may be chosen; otherwise the pointer breaks ties.
  always_comb begin
    w_winner = 2'b00;
    if (r_grant != 2'b00)
      w_winner = r_grant & i_valid;
    else if (i_valid == 2'b11)
      w_winner = r_ptr ? 2'b10 : 2'b01;
    else
      w_winner = i_valid;
  end

  assign w_win_idx = w_winner[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant <= 2'b00;
      r_ptr   <= 1'b0;
    end else if (i_accept) begin
      if (i_last[w_win_idx]) begin
        // End of packet (or single-byte packet): release and favour the other side
        r_grant <= 2'b00;
        r_ptr   <= ~w_win_idx;
      end else begin
        r_grant <= w_winner;
      end
    end else if (i_timeout) begin
      r_grant <= 2'b00;
      r_ptr   <= ~r_grant[1];
    end
  end

  assign o_winner = w_winner;
  assign o_grant  = r_grant;

endmodule

// File: rtl/uart_port_sharer.sv
// Sequences CoreUART CSN/WEN/OEN accesses for two TX requesters and one RX consumer.
// Ports: req_* byte streams in, rx_* byte + error flags out (valid/ready), uart_* to the UART.
// Optional: define UART_PORT_SHARER_TIMEOUT_EN to revoke a starved mid-packet grant.
module uart_port_sharer
  import uart_port_sharer_pkg::*;
#(
  parameter int TX_SETTLE      = 2,
  parameter int RX_SETTLE      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic [1:0]  grant,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic [2:0]  rx_err,
  input  logic        rx_ready,
  output logic        uart_csn,
  output logic        uart_wen,
  output logic        uart_oen,
  output logic [7:0]  uart_wdata,
  input  logic [7:0]  uart_rdata,
  input  logic        uart_txrdy,
  input  logic        uart_rxrdy,
  input  logic        uart_perr,
  input  logic        uart_ferr,
  input  logic        uart_ovf,
  output logic        timeout_pulse
);

  state_e              r_state;
  logic [SETTLE_W-1:0] r_settle;
  logic                r_csn;
  logic                r_wen;
  logic                r_oen;
  logic [7:0]          r_wdata;
  logic                r_rx_valid;
  logic [7:0]          r_rx_data;
  logic [2:0]          r_rx_err;

  logic [1:0]          w_winner;
  logic [1:0]          w_grant;
  logic                w_rd_go;
  logic                w_wr_go;
  logic                w_accept;
  logic                w_timeout;
  logic [7:0]          w_wr_byte;
  logic [2:0]          w_err;

  // RX has priority so the UART receive buffer cannot overflow behind TX traffic.
  assign w_rd_go   = uart_rxrdy & ~r_rx_valid;
  assign w_wr_go   = ~w_rd_go & uart_txrdy & (w_winner != 2'b00);
  assign w_accept  = (r_state == ST_IDLE) & w_wr_go;
  assign req_ready = w_accept ? w_winner : 2'b00;
  assign w_wr_byte = w_winner[1] ? req_data[15:8] : req_data[7:0];

  always_comb begin
    w_err             = 3'b000;
    w_err[RX_ERR_PAR] = uart_perr;
    w_err[RX_ERR_FRM] = uart_ferr;
    w_err[RX_ERR_OVF] = uart_ovf;
  end

  uart_rr_lock_arb u_arb (
    .i_clk     (CLK),
    .i_rst_n   (RESET_N),
    .i_valid   (req_valid),
    .i_last    (req_last),
    .i_accept  (w_accept),
    .i_timeout (w_timeout),
    .o_winner  (w_winner),
    .o_grant   (w_grant)
  );

  // Strobes are registered so an async reset forces them high immediately.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= ST_IDLE;
      r_settle <= '0;
      r_csn    <= 1'b1;
      r_wen    <= 1'b1;
      r_oen    <= 1'b1;
      r_wdata  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rd_go) begin
            r_state <= ST_READ;
            r_csn   <= 1'b0;
            r_oen   <= 1'b0;
          end else if (w_wr_go) begin
            r_state <= ST_WRITE;
            r_csn   <= 1'b0;
            r_wen   <= 1'b0;
            r_wdata <= w_wr_byte;
          end
        end
        ST_WRITE: begin
          r_state  <= ST_TX_WAIT;
          r_csn    <= 1'b1;
          r_wen    <= 1'b1;
          r_settle <= '0;
        end
        ST_TX_WAIT: begin
          if (r_settle == SETTLE_W'(TX_SETTLE - 1)) r_state <= ST_IDLE;
          else r_settle <= r_settle + 1'b1;
        end
        ST_READ: begin
          r_state  <= ST_RX_WAIT;
          r_csn    <= 1'b1;
          r_oen    <= 1'b1;
          r_settle <= '0;
        end
        ST_RX_WAIT: begin
          if (r_settle == SETTLE_W'(RX_SETTLE - 1)) r_state <= ST_IDLE;
          else r_settle <= r_settle + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // READ is only entered with the output register empty, so capture never collides with a drain.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_err   <= 3'b000;
    end else if (r_state == ST_READ) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= uart_rdata;
      r_rx_err   <= w_err;
    end else if (r_rx_valid && rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

`ifdef UART_PORT_SHARER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_to_pulse;
  logic            w_starve;

  // Starving: a packet is open but its owner has nothing to offer.
  assign w_starve  = (w_grant != 2'b00) && ((w_grant & req_valid) == 2'b00);
  assign w_timeout = w_starve && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_to_cnt   <= '0;
      r_to_pulse <= 1'b0;
    end else begin
      r_to_pulse <= w_timeout;
      if (w_accept || w_timeout || (w_grant == 2'b00)) r_to_cnt <= '0;
      else if (w_starve) r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign timeout_pulse = r_to_pulse;
`else
  assign w_timeout     = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  assign grant      = w_grant;
  assign rx_valid   = r_rx_valid;
  assign rx_data    = r_rx_data;
  assign rx_err     = r_rx_err;
  assign uart_csn   = r_csn;
  assign uart_wen   = r_wen;
  assign uart_oen   = r_oen;
  assign uart_wdata = r_wdata;

endmodule

// File: tb/tb_uart_port_sharer.sv
// Scoreboard bench for uart_port_sharer: directed packets, UART RX model, strobe monitor.
// Expected UART writes {grant,data} and RX deliveries {err,data} are queued at issue time.
// Honours UART_PORT_SHARER_TIMEOUT_EN for the grant starvation scenario.
module tb_uart_port_sharer;

  localparam int TXS = 2;
  localparam int RXS = 2;
  localparam int TOC = 16;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  req_last = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [2:0]  rx_err;
  logic        rx_ready = 1'b0;
  logic        uart_csn, uart_wen, uart_oen;
  logic [7:0]  uart_wdata;
  logic [7:0]  uart_rdata = 8'h00;
  logic        uart_txrdy = 1'b0;
  logic        uart_rxrdy = 1'b0;
  logic        uart_perr = 1'b0, uart_ferr = 1'b0, uart_ovf = 1'b0;
  logic        timeout_pulse;

  uart_port_sharer #(.TX_SETTLE(TXS), .RX_SETTLE(RXS), .TIMEOUT_CYCLES(TOC)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .grant(grant),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .rx_ready(rx_ready),
    .uart_csn(uart_csn), .uart_wen(uart_wen), .uart_oen(uart_oen),
    .uart_wdata(uart_wdata), .uart_rdata(uart_rdata),
    .uart_txrdy(uart_txrdy), .uart_rxrdy(uart_rxrdy),
    .uart_perr(uart_perr), .uart_ferr(uart_ferr), .uart_ovf(uart_ovf),
    .timeout_pulse(timeout_pulse)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  logic [8:0]  rq0[$];     // {last, data} pending for requester 0
  logic [8:0]  rq1[$];
  logic [10:0] rxq[$];     // UART receive buffer {ovf, ferr, perr, data}
  logic [9:0]  exp_tx[$];  // {grant during WRITE, data}
  logic [10:0] exp_rx[$];  // {rx_err, rx_data}
  logic        rx_en = 1'b0;

  int n_rd = 0;
  int last_strobe_cyc = -1;
  bit last_was_wr = 1'b0;
  int last_wr_cyc = 0;
  int last_rd_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester drivers and UART RX model: sample handshakes mid-cycle, update after the edge.
  initial begin : drv
    bit acc0, acc1, rd_seen;
    forever begin
      @(negedge CLK);
      acc0    = req_valid[0] & req_ready[0];
      acc1    = req_valid[1] & req_ready[1];
      rd_seen = RESET_N & ~uart_oen;
      @(posedge CLK);
      #1;
      if (acc0 && rq0.size() > 0) void'(rq0.pop_front());
      if (acc1 && rq1.size() > 0) void'(rq1.pop_front());
      if (rd_seen && rxq.size() > 0) void'(rxq.pop_front());
      req_valid[0]  = (rq0.size() > 0);
      req_data[7:0] = (rq0.size() > 0) ? rq0[0][7:0] : 8'h00;
      req_last[0]   = (rq0.size() > 0) ? rq0[0][8] : 1'b0;
      req_valid[1]  = (rq1.size() > 0);
      req_data[15:8]= (rq1.size() > 0) ? rq1[0][7:0] : 8'h00;
      req_last[1]   = (rq1.size() > 0) ? rq1[0][8] : 1'b0;
      uart_rxrdy    = rx_en && (rxq.size() > 0);
      {uart_ovf, uart_ferr, uart_perr, uart_rdata} = (rxq.size() > 0) ? rxq[0] : 11'h000;
    end
  end

  // Monitor: strobe legality, UART write scoreboard, RX delivery scoreboard.
  initial begin : mon
    logic [9:0]  et;
    logic [10:0] er;
    forever begin
      @(negedge CLK);
      if (RESET_N) begin
        if (!uart_wen || !uart_oen) begin
          chk("strobe_excl", {31'd0, uart_wen | uart_oen}, 32'd1);
          chk("csn_low", {31'd0, uart_csn}, 32'd0);
          if (last_strobe_cyc >= 0)
            chk("strobe_gap", {31'd0, (cyc - last_strobe_cyc) >= (last_was_wr ? TXS + 1 : RXS + 1)}, 32'd1);
          last_strobe_cyc = cyc;
          last_was_wr     = !uart_wen;
        end
        if (!uart_wen) begin
          last_wr_cyc = cyc;
          if (exp_tx.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL tx_unexpected: wrote %0h with nothing expected", uart_wdata);
          end else begin
            et = exp_tx.pop_front();
            chk("tx_data", {24'd0, uart_wdata}, {24'd0, et[7:0]});
            chk("tx_grant", {30'd0, grant}, {30'd0, et[9:8]});
          end
        end
        if (!uart_oen) begin
          n_rd++;
          last_rd_cyc = cyc;
        end
        if (rx_valid && rx_ready) begin
          if (exp_rx.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL rx_unexpected: got %0h err %0h with nothing expected", rx_data, rx_err);
          end else begin
            er = exp_rx.pop_front();
            chk("rx_byte", {21'd0, rx_err, rx_data}, {21'd0, er});
          end
        end
      end
    end
  end

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      @(posedge CLK);
      if (exp_tx.size() == 0 && exp_rx.size() == 0 && rq0.size() == 0 &&
          rq1.size() == 0 && rxq.size() == 0) break;
    end
    chk(name, {31'd0, i < 400}, 32'd1);
    repeat (6) @(posedge CLK);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n_rd0;
    bit found;
    // Reset state
    #12;
    chk("rst_strobes", {29'd0, uart_csn, uart_wen, uart_oen}, 32'h7);
    chk("rst_wdata", {24'd0, uart_wdata}, 32'h0);
    chk("rst_grant", {30'd0, grant}, 32'h0);
    chk("rst_ready", {30'd0, req_ready}, 32'h0);
    chk("rst_rx", {20'd0, rx_valid, rx_err, rx_data}, 32'h0);
    chk("rst_timeout", {31'd0, timeout_pulse}, 32'h0);
    @(posedge CLK); #1;
    RESET_N = 1'b1; uart_txrdy = 1'b1; rx_en = 1'b1; rx_ready = 1'b1;

    // Packet lock: req0 three bytes win over a waiting single-byte req1
    rq0.push_back({1'b0, 8'h11}); rq0.push_back({1'b0, 8'h22}); rq0.push_back({1'b1, 8'h33});
    rq1.push_back({1'b1, 8'hAA});
    exp_tx.push_back({2'b01, 8'h11}); exp_tx.push_back({2'b01, 8'h22});
    exp_tx.push_back({2'b00, 8'h33}); exp_tx.push_back({2'b00, 8'hAA});
    drain("drain_pkt");

    // Single-byte packets from both sides alternate
    for (int i = 1; i <= 3; i++) begin
      rq0.push_back({1'b1, 8'(i)});
      rq1.push_back({1'b1, 8'(8'h80 + i)});
    end
    for (int i = 1; i <= 3; i++) begin
      exp_tx.push_back({2'b00, 8'(i)});
      exp_tx.push_back({2'b00, 8'(8'h80 + i)});
    end
    drain("drain_alt");

    // RX and TX ready in the same cycle: read goes first
    uart_txrdy = 1'b0; rx_en = 1'b0;
    rxq.push_back({3'b000, 8'h5A}); exp_rx.push_back({3'b000, 8'h5A});
    rq0.push_back({1'b1, 8'h55});   exp_tx.push_back({2'b00, 8'h55});
    repeat (3) @(posedge CLK);
    #1;
    uart_txrdy = 1'b1; rx_en = 1'b1; uart_rxrdy = 1'b1;
    drain("drain_rxfirst");
    chk("rd_then_wr", last_wr_cyc - last_rd_cyc, RXS + 2);

    // Consumer stalls: one read only, overflow flag reported on the next byte
    rx_ready = 1'b0;
    n_rd0 = n_rd;
    rxq.push_back({3'b000, 8'h21}); rxq.push_back({3'b100, 8'h22});
    exp_rx.push_back({3'b000, 8'h21}); exp_rx.push_back({3'b100, 8'h22});
    repeat (30) @(posedge CLK);
    @(negedge CLK);
    chk("stall_one_read", n_rd - n_rd0, 1);
    chk("stall_rx_valid", {31'd0, rx_valid}, 32'd1);
    @(posedge CLK); #1;
    rx_ready = 1'b1;
    drain("drain_ovf");
    chk("ovf_two_reads", n_rd - n_rd0, 2);

    // Parity error captured with its byte
    rxq.push_back({3'b001, 8'hC3}); exp_rx.push_back({3'b001, 8'hC3});
    drain("drain_perr");

    // Requester 1 opens a packet and then goes quiet
    rq1.push_back({1'b0, 8'h66}); exp_tx.push_back({2'b10, 8'h66});
    drain("drain_open");
    rq0.push_back({1'b1, 8'h77});
`ifdef UART_PORT_SHARER_TIMEOUT_EN
    exp_tx.push_back({2'b00, 8'h77});
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (timeout_pulse) begin found = 1'b1; break; end
    end
    chk("timeout_seen", {31'd0, found}, 32'd1);
    if (found) begin
      chk("timeout_latency", cyc - last_wr_cyc, TOC);
      chk("timeout_grant", {30'd0, grant}, 32'd0);
      @(negedge CLK);
      chk("timeout_one_cycle", {31'd0, timeout_pulse}, 32'd0);
    end
    drain("drain_timeout");
`else
    repeat (40) @(posedge CLK);
    @(negedge CLK);
    chk("grant_held", {30'd0, grant}, 32'h2);
    chk("no_timeout", {31'd0, timeout_pulse}, 32'd0);
    @(posedge CLK); #1;
    exp_tx.push_back({2'b00, 8'h67}); exp_tx.push_back({2'b00, 8'h77});
    rq1.push_back({1'b1, 8'h67});
    drain("drain_close");
`endif

    // Async reset during a WRITE strobe
    rq0.push_back({1'b0, 8'hB1}); rq0.push_back({1'b1, 8'hB2});
    exp_tx.push_back({2'b01, 8'hB1}); exp_tx.push_back({2'b00, 8'hB2});
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!uart_wen) begin found = 1'b1; break; end
    end
    chk("wr_for_reset", {31'd0, found}, 32'd1);
    chk("grant_pre_rst", {30'd0, grant}, 32'h1);
    #2;
    RESET_N = 1'b0; uart_txrdy = 1'b0;
    #1;
    chk("rst_mid_strobes", {29'd0, uart_csn, uart_wen, uart_oen}, 32'h7);
    chk("rst_mid_grant", {30'd0, grant}, 32'h0);
    repeat (3) @(posedge CLK);
    #1;
    RESET_N = 1'b1; uart_txrdy = 1'b1;
    drain("drain_reset");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
